// File: rtl/foc_openloop_seq_if.sv
// Signal bundle between the open-loop sequencer, its control registers and the foc datapath.
// The master side drives commands and feeds back currents; the slave side is the sequencer.
interface foc_openloop_seq_if;
   logic        start;
   logic        stop;
   logic [15:0] speed;
   logic [15:0] upd_div;
   logic [15:0] uq_target;
   logic [15:0] ud_cmd;
   logic [31:0] ia_in;
   logic [31:0] ib_in;
   logic [31:0] ic_in;
   logic [15:0] angle;
   logic [15:0] ud;
   logic [15:0] uq;
   logic [31:0] ia_cap;
   logic [31:0] ib_cap;
   logic [31:0] ic_cap;
   logic        sample_valid;
   logic        busy;
   logic [1:0]  state;

   modport master (
      output start, stop, speed, upd_div, uq_target, ud_cmd, ia_in, ib_in, ic_in,
      input  angle, ud, uq, ia_cap, ib_cap, ic_cap, sample_valid, busy, state
   );

   modport slave (
      input  start, stop, speed, upd_div, uq_target, ud_cmd, ia_in, ib_in, ic_in,
      output angle, ud, uq, ia_cap, ib_cap, ic_cap, sample_valid, busy, state
   );
endinterface

// File: rtl/foc_openloop_seq.sv
// Open-loop foc sequencer: angle ramp, rate-limited uq soft start/stop, and
// phase-current capture a fixed number of clocks after each command update.
module foc_openloop_seq #(
   parameter int unsigned PIPE_LAT = 2,
   parameter int unsigned UQ_STEP  = 8
) (
   input logic               S_AXI_ACLK,
   input logic               S_AXI_ARESETN,
   foc_openloop_seq_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RAMP_UP = 2'd1,
      RUN     = 2'd2,
      RAMP_DN = 2'd3
   } state_t;

   localparam logic [3:0]         LAT_LOAD = 4'(PIPE_LAT);
   localparam logic [15:0]        STEP_U   = 16'(UQ_STEP);
   localparam logic signed [16:0] STEP_S   = $signed(17'(UQ_STEP));

   state_t             state_r;
   state_t             state_next_s;
   logic [15:0]        tick_cnt_r;
   logic               tick_s;
   logic [3:0]         lat_cnt_r;
   logic [15:0]        angle_r;
   logic [15:0]        ud_r;
   logic [15:0]        uq_r;
   logic [31:0]        ia_cap_r;
   logic [31:0]        ib_cap_r;
   logic [31:0]        ic_cap_r;
   logic               sample_valid_r;
   logic               busy_r;
   logic signed [15:0] uq_goal_s;
   logic signed [16:0] uq_diff_s;
   logic [15:0]        uq_next_s;

   assign tick_s = (state_r != IDLE) && (tick_cnt_r == bus.upd_div);

   // Rate-limited step of uq toward its goal; the difference is one bit wider so it cannot wrap.
   always_comb begin
      uq_goal_s = 16'sd0;
      uq_diff_s = 17'sd0;
      uq_next_s = uq_r;
      if (state_r == RAMP_DN) begin
         uq_goal_s = 16'sd0;
      end else begin
         uq_goal_s = $signed(bus.uq_target);
      end
      uq_diff_s = $signed({uq_goal_s[15], uq_goal_s}) - $signed({uq_r[15], uq_r});
      if (uq_diff_s > STEP_S) begin
         uq_next_s = uq_r + STEP_U;
      end else if (uq_diff_s < -STEP_S) begin
         uq_next_s = uq_r - STEP_U;
      end else begin
         uq_next_s = uq_goal_s;
      end
   end

   // Next-state logic; stop has priority over start and over the ramp-up completion.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start && !bus.stop) begin
               state_next_s = RAMP_UP;
            end else begin
               state_next_s = IDLE;
            end
         end
         RAMP_UP: begin
            if (bus.stop) begin
               state_next_s = RAMP_DN;
            end else if (tick_s && (uq_next_s == bus.uq_target)) begin
               state_next_s = RUN;
            end else begin
               state_next_s = RAMP_UP;
            end
         end
         RUN: begin
            if (bus.stop) begin
               state_next_s = RAMP_DN;
            end else begin
               state_next_s = RUN;
            end
         end
         RAMP_DN: begin
            if (tick_s && (uq_next_s == 16'd0)) begin
               state_next_s = IDLE;
            end else begin
               state_next_s = RAMP_DN;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register and its registered busy flag.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         state_r <= IDLE;
         busy_r  <= 1'b0;
      end else begin
         state_r <= state_next_s;
         busy_r  <= (state_next_s != IDLE);
      end
   end

   // Update-tick divider; held clear while idle so the first tick lands upd_div+1 clocks after start.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         tick_cnt_r <= 16'd0;
      end else if ((state_r == IDLE) || tick_s) begin
         tick_cnt_r <= 16'd0;
      end else begin
         tick_cnt_r <= tick_cnt_r + 16'd1;
      end
   end

   // Command outputs: angle advances and ud/uq update only on ticks; angle clears on start.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         angle_r <= 16'd0;
         ud_r    <= 16'd0;
         uq_r    <= 16'd0;
      end else if (state_r == IDLE) begin
         if (state_next_s == RAMP_UP) begin
            angle_r <= 16'd0;
         end
      end else if (tick_s) begin
         angle_r <= angle_r + bus.speed;
         uq_r    <= uq_next_s;
         if (state_r == RAMP_DN) begin
            ud_r <= 16'd0;
         end else begin
            ud_r <= bus.ud_cmd;
         end
      end
   end

   // Latency counter and current capture; a new tick supersedes a capture still in flight.
   always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
         lat_cnt_r      <= 4'd0;
         ia_cap_r       <= 32'd0;
         ib_cap_r       <= 32'd0;
         ic_cap_r       <= 32'd0;
         sample_valid_r <= 1'b0;
      end else begin
         sample_valid_r <= 1'b0;
         if (tick_s) begin
            lat_cnt_r <= LAT_LOAD;
         end else if (lat_cnt_r != 4'd0) begin
            lat_cnt_r <= lat_cnt_r - 4'd1;
            if (lat_cnt_r == 4'd1) begin
               ia_cap_r       <= bus.ia_in;
               ib_cap_r       <= bus.ib_in;
               ic_cap_r       <= bus.ic_in;
               sample_valid_r <= 1'b1;
            end
         end
      end
   end

   assign bus.state        = state_r;
   assign bus.busy         = busy_r;
   assign bus.angle        = angle_r;
   assign bus.ud           = ud_r;
   assign bus.uq           = uq_r;
   assign bus.ia_cap       = ia_cap_r;
   assign bus.ib_cap       = ib_cap_r;
   assign bus.ic_cap       = ic_cap_r;
   assign bus.sample_valid = sample_valid_r;

endmodule

// File: tb/tb_foc_openloop_seq.sv
// Self-checking bench for foc_openloop_seq: a tick-level behavioural model predicts
// state, angle, ud/uq and capture strobes, and every test compares the DUT each clock.
module tb_foc_openloop_seq;
   localparam int PIPE_LAT = 2;
   localparam int UQ_STEP  = 8;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   foc_openloop_seq_if bus ();

   foc_openloop_seq #(.PIPE_LAT(PIPE_LAT), .UQ_STEP(UQ_STEP)) dut (
      .S_AXI_ACLK   (clk),
      .S_AXI_ARESETN(rst_n),
      .bus          (bus)
   );

   // Fake foc currents derived from the commanded angle
   assign bus.ia_in = {16'd0, bus.angle} * 32'd3;
   assign bus.ib_in = {16'd0, bus.angle} + 32'd7;
   assign bus.ic_in = {16'hFFFF, ~bus.angle};

   int n_checks = 0;
   int n_fail   = 0;

   int          m_state    = 0;
   int          m_uq       = 0;
   int          m_ud       = 0;
   logic [15:0] m_angle    = 16'd0;
   logic [15:0] m_speed    = 16'd0;
   int          tgt        = 0;
   int          udc        = 0;
   int          per        = 1;
   int          phase      = 0;
   int          since_tick = 0;
   bit          have_tick  = 1'b0;
   logic [15:0] cap_angle  = 16'd0;

   function automatic logic [50:0] obs_vec();
      return {bus.busy, bus.state, bus.uq, bus.angle, bus.ud};
   endfunction

   function automatic logic [50:0] exp_vec();
      return {(m_state != 0), 2'(m_state), 16'(m_uq), m_angle, 16'(m_ud)};
   endfunction

   function automatic logic exp_sv();
      return have_tick && (since_tick == PIPE_LAT);
   endfunction

   function automatic logic [95:0] obs_caps();
      return {bus.ia_cap, bus.ib_cap, bus.ic_cap};
   endfunction

   function automatic logic [95:0] exp_caps();
      return {({16'd0, cap_angle} * 32'd3), ({16'd0, cap_angle} + 32'd7), {16'hFFFF, ~cap_angle}};
   endfunction

   task automatic set_cfg(input logic [15:0] spd, input int div, input int target, input int udv);
      m_speed       = spd;
      per           = div + 1;
      tgt           = target;
      udc           = udv;
      bus.speed     = spd;
      bus.upd_div   = 16'(div);
      bus.uq_target = 16'(target);
      bus.ud_cmd    = 16'(udv);
   endtask

   // One update tick: move uq toward its goal without overshoot, advance angle, settle state
   task automatic model_tick();
      int goal;
      goal = (m_state == 3) ? 0 : tgt;
      if (goal - m_uq > UQ_STEP) m_uq = m_uq + UQ_STEP;
      else if (m_uq - goal > UQ_STEP) m_uq = m_uq - UQ_STEP;
      else m_uq = goal;
      m_ud    = (m_state == 3) ? 0 : udc;
      m_angle = m_angle + m_speed;
      if (m_state == 1 && m_uq == tgt) m_state = 2;
      else if (m_state == 3 && m_uq == 0) m_state = 0;
      cap_angle  = m_angle;
      have_tick  = 1'b1;
      since_tick = 0;
   endtask

   // Drive one clock of commands and advance the model across that clock edge
   task automatic advance(input bit do_stop, input bit do_start);
      int s_old;
      bus.stop  = do_stop;
      bus.start = do_start;
      @(negedge clk);
      bus.stop  = 1'b0;
      bus.start = 1'b0;
      s_old = m_state;
      since_tick++;
      if (s_old != 0) begin
         phase++;
         if (phase == per) begin
            phase = 0;
            model_tick();
         end
      end
      if (do_stop && (s_old == 1 || s_old == 2)) m_state = 3;
      if (do_start && !do_stop && s_old == 0) begin
         m_state = 1;
         m_angle = 16'd0;
         phase   = 0;
      end
   endtask

   task automatic test_reset();
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      set_cfg(16'd0, 0, 0, 0);
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      n_checks++;
      if ({obs_vec(), bus.sample_valid, obs_caps()} !== '0) begin
         n_fail++;
         $display("FAIL reset_state got %h sv=%b caps=%h want all zero", obs_vec(), bus.sample_valid, obs_caps());
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      advance(1'b0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec() || bus.sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_release got %h sv=%b want %h sv=0", obs_vec(), bus.sample_valid, exp_vec());
      end
   endtask

   task automatic test_soft_start();
      bit seen_cap = 1'b0;
      set_cfg(16'h0100, 9, 40, 5);
      advance(1'b0, 1'b1);
      n_checks++;
      if (bus.state !== 2'd1 || bus.angle !== 16'h0000 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL start_entry got state=%0d angle=%h busy=%b want 1 0000 1", bus.state, bus.angle, bus.busy);
      end
      for (int k = 0; k < 55; k++) begin
         advance(1'b0, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec() || bus.sample_valid !== exp_sv() || (exp_sv() && obs_caps() !== exp_caps())) begin
            n_fail++;
            $display("FAIL soft_start clk %0d got %h sv=%b caps=%h want %h sv=%b caps=%h", k, obs_vec(),
                     bus.sample_valid, obs_caps(), exp_vec(), exp_sv(), exp_caps());
         end
         if (exp_sv() && !seen_cap) begin
            seen_cap = 1'b1;
            n_checks++;
            if (bus.ia_cap !== 32'h0000_0300) begin
               n_fail++;
               $display("FAIL first_capture got ia_cap=%h want 00000300", bus.ia_cap);
            end
         end
      end
      n_checks++;
      if (bus.state !== 2'd2 || bus.angle !== 16'h0500 || bus.uq !== 16'd40 || bus.ud !== 16'd5) begin
         n_fail++;
         $display("FAIL soft_start_end got state=%0d angle=%h uq=%0d ud=%0d want 2 0500 40 5",
                  bus.state, bus.angle, bus.uq, bus.ud);
      end
   endtask

   task automatic test_soft_stop();
      int idle_cnt = 0;
      advance(1'b1, 1'b0);
      n_checks++;
      if (bus.state !== 2'd3 || bus.uq !== 16'd40) begin
         n_fail++;
         $display("FAIL stop_entry got state=%0d uq=%0d want 3 40", bus.state, bus.uq);
      end
      for (int k = 0; k < 300 && idle_cnt < 12; k++) begin
         advance(1'b0, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec() || bus.sample_valid !== exp_sv() || (exp_sv() && obs_caps() !== exp_caps())) begin
            n_fail++;
            $display("FAIL soft_stop clk %0d got %h sv=%b want %h sv=%b", k, obs_vec(), bus.sample_valid,
                     exp_vec(), exp_sv());
         end
         if (m_state == 0) idle_cnt++;
      end
      n_checks++;
      if (bus.state !== 2'd0 || bus.busy !== 1'b0 || bus.uq !== 16'd0 || bus.ud !== 16'd0 || bus.angle !== 16'h0A00) begin
         n_fail++;
         $display("FAIL soft_stop_end got state=%0d busy=%b uq=%0d ud=%0d angle=%h want 0 0 0 0 0a00",
                  bus.state, bus.busy, bus.uq, bus.ud, bus.angle);
      end
   endtask

   task automatic test_no_sample();
      int pulses = 0;
      int idle_cnt = 0;
      set_cfg(16'h0123, 1, 16, 2);
      advance(1'b0, 1'b1);
      for (int k = 0; k < 40; k++) begin
         advance(1'b0, 1'b0);
         if (bus.sample_valid === 1'b1) pulses++;
         n_checks++;
         if (obs_vec() !== exp_vec() || bus.sample_valid !== exp_sv()) begin
            n_fail++;
            $display("FAIL no_sample clk %0d got %h sv=%b want %h sv=%b", k, obs_vec(), bus.sample_valid,
                     exp_vec(), exp_sv());
         end
      end
      n_checks++;
      if (pulses !== 0) begin
         n_fail++;
         $display("FAIL no_sample_count got %0d strobes want 0", pulses);
      end
      advance(1'b1, 1'b0);
      for (int k = 0; k < 200 && idle_cnt < PIPE_LAT + 2; k++) begin
         advance(1'b0, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec() || bus.sample_valid !== exp_sv() || (exp_sv() && obs_caps() !== exp_caps())) begin
            n_fail++;
            $display("FAIL no_sample_drain clk %0d got %h sv=%b want %h sv=%b", k, obs_vec(), bus.sample_valid,
                     exp_vec(), exp_sv());
         end
         if (m_state == 0) idle_cnt++;
      end
   endtask

   task automatic test_wrap_clamp();
      logic [15:0] ang_exp [4];
      int          uq_up   [4];
      int          uq_dn   [8];
      int          idle_cnt = 0;
      ang_exp = '{16'h4000, 16'h8000, 16'hC000, 16'h0000};
      uq_up   = '{8, 16, 20, 20};
      uq_dn   = '{12, 4, -4, -12, -20, -24, -24, -24};
      set_cfg(16'h4000, 0, 20, -3);
      advance(1'b0, 1'b1);
      for (int k = 0; k < 4; k++) begin
         advance(1'b0, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec() || bus.angle !== ang_exp[k] || bus.uq !== 16'(uq_up[k])) begin
            n_fail++;
            $display("FAIL wrap_up clk %0d got %h want %h (angle %h uq %0d)", k, obs_vec(), exp_vec(),
                     ang_exp[k], uq_up[k]);
         end
      end
      tgt = -24;
      bus.uq_target = 16'(tgt);
      for (int k = 0; k < 8; k++) begin
         advance(1'b0, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec() || bus.uq !== 16'(uq_dn[k]) || bus.state !== 2'd2) begin
            n_fail++;
            $display("FAIL clamp_neg clk %0d got %h want %h (uq %0d)", k, obs_vec(), exp_vec(), uq_dn[k]);
         end
      end
      advance(1'b1, 1'b0);
      for (int k = 0; k < 200 && idle_cnt < PIPE_LAT + 2; k++) begin
         advance(1'b0, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec() || bus.sample_valid !== exp_sv() || (exp_sv() && obs_caps() !== exp_caps())) begin
            n_fail++;
            $display("FAIL wrap_drain clk %0d got %h sv=%b want %h sv=%b", k, obs_vec(), bus.sample_valid,
                     exp_vec(), exp_sv());
         end
         if (m_state == 0) idle_cnt++;
      end
   endtask

   task automatic test_collisions();
      int idle_cnt = 0;
      int dn_steps = 0;
      logic [15:0] prev_uq;
      set_cfg(16'h0040, 3, 16, 1);
      advance(1'b1, 1'b1);
      n_checks++;
      if (bus.state !== 2'd0 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL start_stop_idle got state=%0d busy=%b want 0 0", bus.state, bus.busy);
      end
      advance(1'b0, 1'b1);
      for (int k = 0; k < 60 && m_state != 2; k++) advance(1'b0, 1'b0);
      advance(1'b0, 1'b1);
      for (int k = 0; k < 10; k++) begin
         advance(1'b0, 1'b0);
         n_checks++;
         if (obs_vec() !== exp_vec() || bus.state !== 2'd2) begin
            n_fail++;
            $display("FAIL start_in_run clk %0d got %h want %h", k, obs_vec(), exp_vec());
         end
      end
      advance(1'b1, 1'b0);
      for (int k = 0; k < 100 && m_state != 0; k++) advance(1'b0, 1'b0);
      repeat (PIPE_LAT + 2) advance(1'b0, 1'b0);
      // Stop during ramp-up once uq reaches 16
      set_cfg(16'h0010, 3, 40, 9);
      advance(1'b0, 1'b1);
      for (int k = 0; k < 60 && m_uq != 16; k++) advance(1'b0, 1'b0);
      advance(1'b1, 1'b0);
      n_checks++;
      if (bus.state !== 2'd3 || bus.uq !== 16'd16) begin
         n_fail++;
         $display("FAIL stop_in_ramp_up got state=%0d uq=%0d want 3 16", bus.state, bus.uq);
      end
      prev_uq = bus.uq;
      for (int k = 0; k < 100 && idle_cnt < PIPE_LAT + 2; k++) begin
         advance(1'b0, 1'b0);
         if (bus.uq !== prev_uq) dn_steps++;
         prev_uq = bus.uq;
         n_checks++;
         if (obs_vec() !== exp_vec() || bus.sample_valid !== exp_sv()) begin
            n_fail++;
            $display("FAIL ramp_up_stop clk %0d got %h sv=%b want %h sv=%b", k, obs_vec(), bus.sample_valid,
                     exp_vec(), exp_sv());
         end
         if (m_state == 0) idle_cnt++;
      end
      n_checks++;
      if (dn_steps !== 2 || bus.state !== 2'd0 || bus.uq !== 16'd0) begin
         n_fail++;
         $display("FAIL ramp_up_stop_end got steps=%0d state=%0d uq=%0d want 2 0 0", dn_steps, bus.state, bus.uq);
      end
   endtask

   task automatic test_random();
      int run_len;
      int idle_cnt;
      for (int r = 0; r < 5; r++) begin
         set_cfg(16'($urandom), int'($urandom_range(0, 6)), int'($urandom_range(0, 400)) - 200,
                 int'($urandom_range(0, 1000)) - 500);
         advance(1'b0, 1'b1);
         run_len = int'($urandom_range(10, 90));
         for (int k = 0; k < run_len; k++) begin
            if (k == run_len / 2) begin
               tgt = int'($urandom_range(0, 400)) - 200;
               bus.uq_target = 16'(tgt);
            end
            advance(1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec() || bus.sample_valid !== exp_sv() || (exp_sv() && obs_caps() !== exp_caps())) begin
               n_fail++;
               $display("FAIL random run %0d clk %0d got %h sv=%b want %h sv=%b", r, k, obs_vec(),
                        bus.sample_valid, exp_vec(), exp_sv());
            end
         end
         advance(1'b1, 1'b0);
         idle_cnt = 0;
         for (int k = 0; k < 400 && idle_cnt < PIPE_LAT + 2; k++) begin
            advance(1'b0, 1'b0);
            n_checks++;
            if (obs_vec() !== exp_vec() || bus.sample_valid !== exp_sv() || (exp_sv() && obs_caps() !== exp_caps())) begin
               n_fail++;
               $display("FAIL random_stop run %0d clk %0d got %h sv=%b want %h sv=%b", r, k, obs_vec(),
                        bus.sample_valid, exp_vec(), exp_sv());
            end
            if (m_state == 0) idle_cnt++;
         end
         n_checks++;
         if (bus.state !== 2'd0 || bus.busy !== 1'b0 || bus.uq !== 16'd0) begin
            n_fail++;
            $display("FAIL random_idle run %0d got state=%0d busy=%b uq=%0d want 0 0 0", r, bus.state, bus.busy, bus.uq);
         end
      end
   endtask

   task automatic test_reset_mid();
      set_cfg(16'h0100, 0, 40, 5);
      advance(1'b0, 1'b1);
      repeat (8) advance(1'b0, 1'b0);
      n_checks++;
      if (bus.state !== 2'd2 || bus.uq !== 16'd40) begin
         n_fail++;
         $display("FAIL reset_mid_setup got state=%0d uq=%0d want 2 40", bus.state, bus.uq);
      end
      #2 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({obs_vec(), bus.sample_valid, obs_caps()} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid got %h sv=%b caps=%h want all zero", obs_vec(), bus.sample_valid, obs_caps());
      end
      @(negedge clk);
      rst_n      = 1'b1;
      m_state    = 0;
      m_uq       = 0;
      m_ud       = 0;
      m_angle    = 16'd0;
      phase      = 0;
      have_tick  = 1'b0;
      repeat (2) advance(1'b0, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec() || bus.sample_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_mid_release got %h sv=%b want %h sv=0", obs_vec(), bus.sample_valid, exp_vec());
      end
   endtask

   initial begin
      test_reset();
      test_soft_start();
      test_soft_stop();
      test_no_sample();
      test_wrap_clamp();
      test_collisions();
      test_random();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
